// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core_top stage sequencer: stage codes, FSM states
// and the stage-index to stage-code mapping.
package core_ctrl_pkg;

  localparam int NUM_STAGES = 8;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_Q_GEN  = 4'd1;
  localparam logic [3:0] S_K_GEN  = 4'd2;
  localparam logic [3:0] S_V_GEN  = 4'd3;
  localparam logic [3:0] S_ATT_QK = 4'd4;
  localparam logic [3:0] S_ATT_PV = 4'd5;
  localparam logic [3:0] S_PROJ   = 4'd6;
  localparam logic [3:0] S_FFN0   = 4'd7;
  localparam logic [3:0] S_FFN1   = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_PUSH,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_RETIRE
  } seq_state_e;

  // stage_en bit i selects stage code i+1
  function automatic logic [3:0] stage_code(input int idx);
    return 4'(idx + 1);
  endfunction

endpackage

// File: rtl/stage_pick_pe.sv
// Lowest-set-bit priority encoder over the remaining enabled stages; returns
// whether any stage is left and the stage code of the lowest one.
module stage_pick_pe
  import core_ctrl_pkg::*;
(
  input  logic [NUM_STAGES-1:0] req,
  output logic                  found,
  output logic [3:0]            code
);

  always_comb begin
    found = 1'b0;
    code  = S_IDLE;
    // scan downward so the lowest set bit is the last one written
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        code  = stage_code(i);
      end
    end
  end

endmodule

// File: rtl/core_stage_seq.sv
// Stage sequencer for core_top: walks the enabled stages in code order, issues
// control_state/update/start, times each stage and reports perf, timeout and done.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  IDLE      | waiting for run; control_state parked at S_IDLE
//  PICK      | choose lowest remaining enabled stage, or retire if none
//  PUSH      | register control_state=code with a 1-cycle update pulse
//  SETTLE    | hold SETTLE_CYC idle cycles after the update
//  START     | start pulse visible, stage counter cleared
//  WAIT      | count cycles until finish or timeout
//  RETIRE    | control_state back to S_IDLE, busy low, done if clean
module core_stage_seq
  import core_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 24,
  parameter int STATE_W    = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run,
  input  logic               abort,
  input  logic [7:0]         stage_en,
  input  logic [CNT_W-1:0]   timeout_cyc,
  output logic [STATE_W-1:0] control_state,
  output logic               control_state_update,
  output logic               start,
  input  logic               finish,
  output logic               busy,
  output logic [3:0]         cur_stage,
  output logic               perf_vld,
  output logic [3:0]         perf_stage,
  output logic [CNT_W-1:0]   perf_cnt,
  output logic               done,
  output logic               err_timeout
);

  localparam logic [3:0]       SETTLE_L = 4'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  seq_state_e            state_q, state_d;
  logic [NUM_STAGES-1:0] en_q, en_d;
  logic [CNT_W-1:0]      tmo_q, tmo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [3:0]            settle_q, settle_d;
  logic [3:0]            code_q, code_d;

  logic [3:0]            cs_q, cs_d;
  logic                  upd_q, upd_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic [3:0]            cur_q, cur_d;
  logic                  pv_q, pv_d;
  logic [3:0]            ps_q, ps_d;
  logic [CNT_W-1:0]      pc_q, pc_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  pick_found;
  logic [3:0]            pick_code;
  logic                  go_retire;
  logic                  retire_clean;

  stage_pick_pe u_pick (
    .req   (en_q),
    .found (pick_found),
    .code  (pick_code)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    code_d       = code_q;
    cs_d         = cs_q;
    upd_d        = 1'b0;
    start_d      = 1'b0;
    busy_d       = busy_q;
    cur_d        = cur_q;
    pv_d         = 1'b0;
    ps_d         = ps_q;
    pc_d         = pc_q;
    done_d       = 1'b0;
    err_d        = err_q;
    go_retire    = 1'b0;
    retire_clean = 1'b0;

    if (abort && state_q != ST_IDLE && state_q != ST_RETIRE) begin
      go_retire = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run && !abort) begin
            en_d    = stage_en;
            tmo_d   = timeout_cyc;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_PICK;
          end
        end
        ST_PICK: begin
          if (!pick_found) begin
            go_retire    = 1'b1;
            retire_clean = 1'b1;
          end else begin
            code_d  = pick_code;
            en_d    = en_q & (en_q - NUM_STAGES'(1));
            state_d = ST_PUSH;
          end
        end
        ST_PUSH: begin
          cs_d     = code_q;
          upd_d    = 1'b1;
          cur_d    = code_q;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          // start is registered on the way out so it shows during START
          if (settle_q == SETTLE_L) begin
            start_d = 1'b1;
            state_d = ST_START;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        ST_START: begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          cnt_d = cnt_inc;
          if (finish) begin
            pv_d    = 1'b1;
            ps_d    = code_q;
            pc_d    = cnt_inc;
            state_d = ST_PICK;
          end else if (tmo_q != '0 && cnt_inc == tmo_q) begin
            err_d     = 1'b1;
            go_retire = 1'b1;
          end
        end
        ST_RETIRE: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    if (go_retire) begin
      state_d = ST_RETIRE;
      cs_d    = S_IDLE;
      upd_d   = 1'b1;
      busy_d  = 1'b0;
      cur_d   = S_IDLE;
      done_d  = retire_clean & ~err_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      en_q     <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      code_q   <= S_IDLE;
      cs_q     <= S_IDLE;
      upd_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      cur_q    <= S_IDLE;
      pv_q     <= 1'b0;
      ps_q     <= S_IDLE;
      pc_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      code_q   <= code_d;
      cs_q     <= cs_d;
      upd_q    <= upd_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      cur_q    <= cur_d;
      pv_q     <= pv_d;
      ps_q     <= ps_d;
      pc_q     <= pc_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign control_state        = {{(STATE_W-4){1'b0}}, cs_q};
  assign control_state_update = upd_q;
  assign start                = start_q;
  assign busy                 = busy_q;
  assign cur_stage            = cur_q;
  assign perf_vld             = pv_q;
  assign perf_stage           = ps_q;
  assign perf_cnt             = pc_q;
  assign done                 = done_q;
  assign err_timeout          = err_q;

endmodule
